// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 streaming demultiplexer.
package demux_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic { MODE_SEL = 1'b0, MODE_RR = 1'b1 } demux_mode_e;

    typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready output register for a single demux lane.
module demux_lane_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // A fill wins over a drain so a same-edge drain+fill keeps the lane full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            out_data  <= fill_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// Streaming 1-to-4 demux: explicit-select or round-robin lane steering with
// per-lane one-entry output registers.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [LANES-1:0]       lane_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   drop_pulse,
    output logic [SEL_W-1:0]       rr_ptr
);

    demux_mode_e      mode_e;
    logic [SEL_W-1:0] rr_tgt;
    logic             rr_found;
    logic [SEL_W-1:0] tgt;
    logic             tgt_en;
    logic             accept;
    logic             drop;
    lane_mask_t       fill;

    assign mode_e = demux_mode_e'(mode);

    // Circular scan for the first enabled lane at or after rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_tgt   = rr_ptr;
        for (int i = 0; i < int'(LANES); i++) begin
            logic [SEL_W-1:0] idx;
            idx = rr_ptr + SEL_W'(i);
            if (!rr_found && lane_en[idx]) begin
                rr_found = 1'b1;
                rr_tgt   = idx;
            end
        end
    end

    // Disabled select targets accept and discard; an empty RR mask stalls.
    always_comb begin
        tgt      = in_sel;
        tgt_en   = lane_en[in_sel];
        in_ready = 1'b1;
        fill     = '0;
        if (mode_e == MODE_RR) begin
            tgt    = rr_tgt;
            tgt_en = rr_found;
        end
        if (tgt_en) begin
            in_ready = !out_valid[tgt] || out_ready[tgt];
        end else begin
            in_ready = (mode_e == MODE_SEL);
        end
        accept = in_valid && in_ready;
        drop   = accept && !tgt_en;
        if (accept && tgt_en) begin
            fill[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (accept && tgt_en && mode_e == MODE_RR) begin
                rr_ptr <= tgt + SEL_W'(1);
            end
        end
    end

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .fill      (fill[k]),
            .fill_data (in_data),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed self-checking bench for demux_1x4_stream with hand-computed expectations.
module tb_demux_1x4_stream;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [3:0]       lane_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic             drop_pulse;
    logic [1:0]       rr_ptr;

    int n_cmp = 0;
    int n_err = 0;

    demux_1x4_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .lane_en    (lane_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .rr_ptr     (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane_data(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    initial begin
        int exp_lane [6];
        int exp_ptr  [6];
        int sel_seq  [3];
        exp_lane = '{0, 1, 3, 0, 1, 3};
        exp_ptr  = '{1, 2, 0, 1, 2, 0};
        sel_seq  = '{3, 0, 1};

        rst = 1'b1; mode = 1'b0; lane_en = 4'b1111; in_valid = 1'b0;
        in_data = '0; in_sel = '0; out_ready = 4'b1111;
        tick(); tick();
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_ptr", 32'(rr_ptr), 32'h0);
        chk("reset_drop", 32'(drop_pulse), 32'h0);
        chk("reset_data", out_data, 32'h0);
        rst = 1'b0;
        tick();

        // Explicit select, one beat per lane on consecutive cycles
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = 2'(k); in_data = 8'(8'hA0 + k);
            #1;
            chk($sformatf("sel_ready%0d", k), 32'(in_ready), 32'h1);
            tick();
            chk($sformatf("sel_valid%0d", k), 32'(out_valid), 32'(4'b0001 << k));
            chk($sformatf("sel_data%0d", k), 32'(lane_data(k)), 32'(8'hA0 + k));
        end
        in_valid = 1'b0;
        tick();
        chk("sel_drained", 32'(out_valid), 32'h0);
        chk("sel_ptr_held", 32'(rr_ptr), 32'h0);

        // Round robin over lanes 0,1,3
        mode = 1'b1; lane_en = 4'b1011;
        for (int b = 0; b < 6; b++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + b);
            tick();
            chk($sformatf("rr_valid%0d", b), 32'(out_valid), 32'(4'b0001 << exp_lane[b]));
            chk($sformatf("rr_data%0d", b), 32'(lane_data(exp_lane[b])), 32'(8'h10 + b));
            chk($sformatf("rr_ptr%0d", b), 32'(rr_ptr), 32'(exp_ptr[b]));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: lane 1 full and stalled with rr_ptr = 1
        lane_en = 4'b1111; out_ready = 4'b1101;
        mode = 1'b0; in_sel = 2'd1; in_valid = 1'b1; in_data = 8'h30;
        tick();
        mode = 1'b1; in_data = 8'h31;
        tick();
        chk("bp_ptr1", 32'(rr_ptr), 32'h1);
        in_data = 8'h32;
        #1;
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        tick();
        chk("bp_no_skip", 32'(out_valid), 32'b0010);
        chk("bp_hold_data", 32'(lane_data(1)), 32'h30);
        chk("bp_ptr_hold", 32'(rr_ptr), 32'h1);
        out_ready = 4'b1111;
        #1;
        chk("bp_ready_high", 32'(in_ready), 32'h1);
        tick();
        chk("bp_thru_valid", 32'(out_valid), 32'b0010);
        chk("bp_thru_data", 32'(lane_data(1)), 32'h32);
        chk("bp_ptr2", 32'(rr_ptr), 32'h2);
        in_valid = 1'b0;
        tick();

        // Drop on a disabled select target
        mode = 1'b0; lane_en = 4'b1101; in_sel = 2'd1; in_data = 8'h55; in_valid = 1'b1;
        #1;
        chk("drop_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("drop_pulse_hi", 32'(drop_pulse), 32'h1);
        chk("drop_no_valid", 32'(out_valid), 32'h0);
        chk("drop_no_write", 32'(lane_data(1)), 32'h32);
        tick();
        chk("drop_pulse_lo", 32'(drop_pulse), 32'h0);

        // Round robin with nothing enabled stalls
        mode = 1'b1; lane_en = 4'b0000; in_valid = 1'b1; in_data = 8'h66;
        #1;
        chk("rr_none_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rr_none_valid", 32'(out_valid), 32'h0);
        chk("rr_none_ptr", 32'(rr_ptr), 32'h2);
        in_valid = 1'b0;

        // Reset mid-stream with lanes 1 and 2 holding beats
        mode = 1'b0; lane_en = 4'b1111; out_ready = 4'b1001;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h61;
        tick();
        in_sel = 2'd2; in_data = 8'h62;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'b0110);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_ptr", 32'(rr_ptr), 32'h0);
        chk("async_rst_drop", 32'(drop_pulse), 32'h0);
        #2;
        rst = 1'b0;
        out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
        #1;
        chk("post_rst_none", 32'(out_valid), 32'h0);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'b1000);
        chk("post_rst_data", 32'(lane_data(3)), 32'h77);
        tick();

        // Mode switching keeps the round-robin pointer
        mode = 1'b1; in_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_data = 8'(8'h80 + b);
            tick();
        end
        chk("ms_rr_ptr", 32'(rr_ptr), 32'h2);
        mode = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_sel = 2'(sel_seq[b]); in_data = 8'(8'h90 + b);
            tick();
            chk($sformatf("ms_sel_lane%0d", b), 32'(lane_data(sel_seq[b])), 32'(8'h90 + b));
            chk($sformatf("ms_sel_ptr%0d", b), 32'(rr_ptr), 32'h2);
        end
        mode = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("ms_back_valid", 32'(out_valid), 32'b0100);
        chk("ms_back_data", 32'(lane_data(2)), 32'hA5);
        chk("ms_back_ptr", 32'(rr_ptr), 32'h3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Streaming 1-to-4 demultiplexer; the distribution-side counterpart of the team's 4:1 selector.
- Steers one valid/ready input stream to one of four output lanes, each with a one-entry output register.
- Lane choice comes either from an explicit per-beat select or from an internal round-robin pointer that skips disabled lanes.
- Sits between a single producer and four parallel consumers, such as the per-channel datapaths that the 4:1 selector later recombines.

Parameters:
- WIDTH, 8, data width of each beat.
- LANES, 4, number of output lanes; fixed at 4, not overridable. Lives in the package.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = MODE_SEL (in_sel steers), 1 = MODE_RR (round-robin steers).
- lane_en  input  4  per-lane enable mask.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  2  target lane in MODE_SEL; ignored in MODE_RR.
- out_valid  output  4  per-lane output valid.
- out_ready  input  4  per-lane consumer ready.
- out_data  output  4*WIDTH  lane k payload on bits [k*WIDTH +: WIDTH].
- drop_pulse  output  1  one-cycle pulse when a beat is dropped.
- rr_ptr  output  2  current round-robin pointer, for debug and verification.

Behaviour:
- Reset values (asynchronous, immediate): out_valid = 0, out_data = 0, rr_ptr = 0, drop_pulse = 0. Reset mid-transfer discards all held beats. No output is valid until the first beat is accepted after reset release.

Target lane t for the current cycle:
- MODE_SEL: t = in_sel.
- MODE_RR: t = first enabled lane at or after rr_ptr, scanning circularly 0..3. If lane_en == 0, there is no target.

in_ready (combinational; no dependence on in_valid):
- MODE_SEL, lane_en[t] = 1: in_ready = !out_valid[t] || out_ready[t].
- MODE_SEL, lane_en[t] = 0: in_ready = 1. An accepted beat is dropped: nothing is written, and drop_pulse = 1 on the next cycle.
- MODE_RR, a target exists: in_ready = !out_valid[t] || out_ready[t].
- MODE_RR, lane_en == 0: in_ready = 0.
- In MODE_RR the block waits on a full target lane. It never skips a full-but-enabled lane.

Lane register k, each clock:
- Drained when out_valid[k] && out_ready[k].
- Filled when the beat is accepted, lane k is the target, and the beat is not dropped.
- Fill, with or without drain: out_data[k] <= in_data, out_valid[k] <= 1. Simultaneous drain and fill keeps valid high with the new data, giving full throughput.
- Drain only: out_valid[k] <= 0. out_data[k] holds its old value (don't-care).
- Latency is 1 cycle, from accepting edge to out_valid.
- out_data[k] is stable while out_valid[k] && !out_ready[k].

rr_ptr:
- Updates only on an accepted, non-dropped beat in MODE_RR: rr_ptr <= (t + 1) mod 4, wrapping 3 -> 0.
- Held in MODE_SEL and retained across mode changes.

Changes to mode and lane_en:
- Take effect combinationally in the same cycle.
- Disabling a lane that holds a valid beat does not flush it. The beat still drains normally.

drop_pulse:
- Registered; high for exactly one cycle per dropped beat.

Decomposition:
- Package demux_pkg holds:
  - LANES = 4 and SEL_W = 2.
  - typedef enum logic { MODE_SEL = 1'b0, MODE_RR = 1'b1 } demux_mode_e.
  - typedef logic [LANES-1:0] lane_mask_t.
- Sub-module demux_lane_reg: one-entry valid/ready register slice with ports clk, rst, fill, fill_data, out_valid, out_ready, out_data. Instantiated 4 times.
- The top level holds target selection, the circular priority scan, in_ready/drop logic and rr_ptr.

Test Plan:
- Reset: assert rst mid-stream with lanes 1 and 2 valid -> out_valid = 0000, rr_ptr = 0, drop_pulse = 0 immediately. After release, the first accepted beat appears one cycle later.
- MODE_SEL, all out_ready = 1, lane_en = 1111, beats 0xA0..0xA3 with in_sel = 0,1,2,3 on consecutive cycles -> lane k shows 0xA0+k one cycle after its accept. in_ready stays 1 throughout.
- MODE_RR, lane_en = 1011, six beats 0x10..0x15, all ready -> lanes receive 0,1,3,0,1,3, and rr_ptr sequence is 1,2,0,1,2,0 after each accept.
- Backpressure, MODE_RR, out_ready[1] = 0 with lane 1 full and rr_ptr = 1 -> in_ready = 0 and no beat is skipped to lane 2. Raise out_ready[1] -> drain and fill occur on the same edge, and out_valid[1] stays 1 with the new data.
- MODE_SEL, lane_en = 1101, in_sel = 1, in_data = 0x55 -> in_ready = 1, drop_pulse = 1 for exactly one cycle, and no out_valid changes. Separately, MODE_RR with lane_en = 0000 -> in_ready = 0.
- Mode switch: MODE_RR after 2 beats (rr_ptr = 2), then MODE_SEL for 3 beats, then back to MODE_RR -> rr_ptr remains 2, and the next RR beat goes to lane 2.
